// File: rtl/utils_pkg.sv
// utils_pkg: shared types and helpers for the gate vector sequencer.
//   op_e        - expected gate operation selected by op_sel
//   state_e     - sequencer FSM states
//   band        - single-bit AND primitive
//   expected_y  - reference output of the selected gate, built on band
package utils_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    function automatic logic band(input logic a, input logic b);
        return a & b;
    endfunction

    // OR and XOR are derived from AND through De Morgan so every operation
    // shares the one primitive.
    function automatic logic expected_y(input op_e op, input logic a, input logic b);
        logic y;
        case (op)
            OP_AND:  y = band(a, b);
            OP_OR:   y = ~band(~a, ~b);
            OP_XOR:  y = band(~band(~a, ~b), ~band(a, b));
            OP_NAND: y = ~band(a, b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_vector_seq.sv
// gate_vector_seq: drives the four {a,b} vectors into an external 2-input
// gate, waits SETTLE_CYCLES, compares the gate response against the
// selected operation and accumulates check/error counts over PASSES sweeps.
//   clk, rst          - clock, synchronous active-high reset
//   start             - one-cycle run request (accepted in IDLE/DONE)
//   op_sel            - expected operation (AND/OR/XOR/NAND)
//   a_o, b_o, y_i     - stimulus to and response from the gate under test
//   busy, done, pass  - run status
//   err_count         - mismatching checks, saturating
//   vec_count         - checks performed
//   first_fail_vec/valid - {a,b} of the first mismatch
//
// state  | meaning
// IDLE   | waiting for start after reset, a/b held low
// DRIVE  | register next vector onto a_o/b_o
// SETTLE | hold vector for SETTLE_CYCLES
// CHECK  | compare y_i, update counters, pick next vector or finish
// DONE   | results held, a/b low, waiting for start
module gate_vector_seq
    import utils_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op_sel,
    output logic             a_o,
    output logic             b_o,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PASS_LAST   = 16'(PASSES - 1);

    state_e           state_q;
    op_e              op_q;
    logic [1:0]       idx_q;
    logic [15:0]      pass_cnt_q;
    logic [7:0]       settle_cnt_q;
    logic             a_q, b_q;
    logic             busy_q, done_q;
    logic [CNT_W-1:0] err_q, vec_q;
    logic [1:0]       ff_vec_q;
    logic             ff_valid_q;

    logic             mismatch;
    logic             last_vec;
    logic [CNT_W-1:0] err_d;

    assign mismatch = (y_i != expected_y(op_q, a_q, b_q));
    assign last_vec = (idx_q == 2'd3) && (pass_cnt_q == PASS_LAST);
    assign err_d    = (err_q == {CNT_W{1'b1}}) ? err_q : err_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_AND;
            idx_q        <= 2'd0;
            pass_cnt_q   <= 16'd0;
            settle_cnt_q <= 8'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
            vec_q        <= '0;
            ff_vec_q     <= 2'b00;
            ff_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= DRIVE;
                        op_q       <= op_e'(op_sel);
                        err_q      <= '0;
                        vec_q      <= '0;
                        ff_valid_q <= 1'b0;
                        idx_q      <= 2'd0;
                        pass_cnt_q <= 16'd0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                DRIVE: begin
                    a_q          <= idx_q[1];
                    b_q          <= idx_q[0];
                    settle_cnt_q <= SETTLE_LOAD;
                    state_q      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_q == 8'd0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 8'd1;
                    end
                end
                CHECK: begin
                    vec_q <= vec_q + CNT_W'(1);
                    if (mismatch) begin
                        err_q <= err_d;
                        if (!ff_valid_q) begin
                            ff_vec_q   <= {a_q, b_q};
                            ff_valid_q <= 1'b1;
                        end
                    end
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        pass_cnt_q <= pass_cnt_q + 16'd1;
                    end
                    if (last_vec) begin
                        state_q <= DONE;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= DRIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_o              = a_q;
    assign b_o              = b_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = done_q && (err_q == '0);
    assign err_count        = err_q;
    assign vec_count        = vec_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_gate_vector_seq.sv
module tb_gate_vector_seq;

    typedef struct {
        int         lat;
        int         vec;
        bit         chk_vec;
        int         err;
        logic [1:0] ffv;
        logic       ffval;
        logic       pas;
    } exp_t;

    localparam int LIMIT = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op_sel = 2'b00;
    logic [1:0] sel = 2'd0;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    // DUT A: defaults, and gate
    logic sA, aA, bA, yA, busyA, doneA, passA, ffvalA;
    logic [15:0] errA, vecA;
    logic [1:0]  ffvA;
    // DUT B: PASSES=3, and gate
    logic sB, aB, bB, yB, busyB, doneB, passB, ffvalB;
    logic [15:0] errB, vecB;
    logic [1:0]  ffvB;
    // DUT C: CNT_W=2, PASSES=2, y tied high
    logic sC, aC, bC, yC, busyC, doneC, passC, ffvalC;
    logic [1:0]  errC, vecC;
    logic [1:0]  ffvC;

    assign sA = start & (sel == 2'd0);
    assign sB = start & (sel == 2'd1);
    assign sC = start & (sel == 2'd2);
    assign yA = aA & bA;
    assign yB = aB & bB;
    assign yC = 1'b1;

    gate_vector_seq u_a (
        .clk(clk), .rst(rst), .start(sA), .op_sel(op_sel),
        .a_o(aA), .b_o(bA), .y_i(yA), .busy(busyA), .done(doneA), .pass(passA),
        .err_count(errA), .vec_count(vecA),
        .first_fail_vec(ffvA), .first_fail_valid(ffvalA));

    gate_vector_seq #(.PASSES(3)) u_b (
        .clk(clk), .rst(rst), .start(sB), .op_sel(op_sel),
        .a_o(aB), .b_o(bB), .y_i(yB), .busy(busyB), .done(doneB), .pass(passB),
        .err_count(errB), .vec_count(vecB),
        .first_fail_vec(ffvB), .first_fail_valid(ffvalB));

    gate_vector_seq #(.CNT_W(2), .PASSES(2)) u_c (
        .clk(clk), .rst(rst), .start(sC), .op_sel(op_sel),
        .a_o(aC), .b_o(bC), .y_i(yC), .busy(busyC), .done(doneC), .pass(passC),
        .err_count(errC), .vec_count(vecC),
        .first_fail_vec(ffvC), .first_fail_valid(ffvalC));

    logic        a_m, b_m, busy_m, done_m, pass_m, ffval_m;
    logic [15:0] err_m, vec_m;
    logic [1:0]  ffv_m;

    always_comb begin
        a_m = aA; b_m = bA; busy_m = busyA; done_m = doneA; pass_m = passA;
        err_m = errA; vec_m = vecA; ffv_m = ffvA; ffval_m = ffvalA;
        if (sel == 2'd1) begin
            a_m = aB; b_m = bB; busy_m = busyB; done_m = doneB; pass_m = passB;
            err_m = errB; vec_m = vecB; ffv_m = ffvB; ffval_m = ffvalB;
        end else if (sel == 2'd2) begin
            a_m = aC; b_m = bC; busy_m = busyC; done_m = doneC; pass_m = passC;
            err_m = {14'd0, errC}; vec_m = {14'd0, vecC}; ffv_m = ffvC; ffval_m = ffvalC;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_a"}, {31'd0, a_m}, 0);
        check({tag, "_b"}, {31'd0, b_m}, 0);
        check({tag, "_busy"}, {31'd0, busy_m}, 0);
        check({tag, "_done"}, {31'd0, done_m}, 0);
        check({tag, "_pass"}, {31'd0, pass_m}, 0);
        check({tag, "_err"}, {16'd0, err_m}, 0);
        check({tag, "_vec"}, {16'd0, vec_m}, 0);
        check({tag, "_ffv"}, {30'd0, ffv_m}, 0);
        check({tag, "_ffval"}, {31'd0, ffval_m}, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start, waits for done, then pops and compares the expected result.
    // With pulse set, start is re-pulsed and op_sel flipped mid-run.
    task automatic run(input string tag, input logic [1:0] op, input bit pulse);
        int n;
        exp_t e;
        op_sel = op;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done_m && n < LIMIT) begin
            tick();
            n++;
            if (pulse && n == 5) begin
                start = 1'b1;
                op_sel = ~op;
            end
            if (pulse && n == 6) begin
                start = 1'b0;
                check({tag, "_busy_mid"}, {31'd0, busy_m}, 1);
            end
        end
        e = sb.pop_front();
        check({tag, "_latency"}, n, e.lat);
        if (e.chk_vec) check({tag, "_vec"}, {16'd0, vec_m}, e.vec);
        check({tag, "_err"}, {16'd0, err_m}, e.err);
        check({tag, "_ffval"}, {31'd0, ffval_m}, {31'd0, e.ffval});
        check({tag, "_ffv"}, {30'd0, ffv_m}, {30'd0, e.ffv});
        check({tag, "_pass"}, {31'd0, pass_m}, {31'd0, e.pas});
        check({tag, "_busy_done"}, {31'd0, busy_m}, 0);
        check({tag, "_ab_done"}, {30'd0, a_m, b_m}, 0);
        tick();
        tick();
        check({tag, "_done_hold"}, {31'd0, done_m}, 1);
        check({tag, "_err_hold"}, {16'd0, err_m}, e.err);
    endtask

    initial begin
        sel = 2'd0;
        rst = 1'b1;
        tick();
        tick();
        check_reset("rstA");
        sel = 2'd2;
        #1;
        check_reset("rstC");
        sel = 2'd0;
        rst = 1'b0;

        // AND run against an and gate: every vector matches
        sb.push_back('{lat: 16, vec: 4, chk_vec: 1, err: 0, ffv: 2'b00, ffval: 1'b0, pas: 1'b1});
        run("and1", 2'b00, 1'b0);

        // expect OR from an and gate: 01 and 10 mismatch; mid-run start/op change ignored
        sb.push_back('{lat: 16, vec: 4, chk_vec: 1, err: 2, ffv: 2'b01, ffval: 1'b1, pas: 1'b0});
        run("or1", 2'b01, 1'b1);

        // XOR against an and gate: 01, 10, 11 mismatch
        sb.push_back('{lat: 16, vec: 4, chk_vec: 1, err: 3, ffv: 2'b01, ffval: 1'b1, pas: 1'b0});
        run("xor1", 2'b10, 1'b0);

        // NAND against an and gate: all four mismatch
        sb.push_back('{lat: 16, vec: 4, chk_vec: 1, err: 4, ffv: 2'b00, ffval: 1'b1, pas: 1'b0});
        run("nand1", 2'b11, 1'b0);

        // three sweeps, start re-pulsed at cycle 5
        sel = 2'd1;
        #1;
        sb.push_back('{lat: 48, vec: 12, chk_vec: 1, err: 0, ffv: 2'b00, ffval: 1'b0, pas: 1'b1});
        run("pass3", 2'b00, 1'b1);

        // saturation with y stuck high: 6 mismatches clip to 3
        sel = 2'd2;
        #1;
        sb.push_back('{lat: 32, vec: 0, chk_vec: 0, err: 3, ffv: 2'b00, ffval: 1'b1, pas: 1'b0});
        run("sat", 2'b00, 1'b0);

        // reset during SETTLE of vector 10
        sel = 2'd0;
        #1;
        op_sel = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_ab", {30'd0, a_m, b_m}, 2);
        check("mid_busy", {31'd0, busy_m}, 1);
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        sb.push_back('{lat: 16, vec: 4, chk_vec: 1, err: 0, ffv: 2'b00, ffval: 1'b0, pas: 1'b1});
        run("after_rst", 2'b00, 1'b0);

        // rst and start together from DONE: lands in IDLE
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'd0, busy_m}, 0);
        check("rst_start_done", {31'd0, done_m}, 0);
        tick();
        check("rst_start_busy2", {31'd0, busy_m}, 0);
        check("rst_start_vec", {16'd0, vec_m}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_vector_seq.md
GATE_VECTOR_SEQ -- requirements
Module: gate_vector_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of cycles the vector is held before y_i is sampled; legal range 1..255.
REQ-002 Parameter PASSES, default 1, number of full 4-vector sweeps per run; legal range 1..65535.
REQ-003 Parameter CNT_W, default 16, width of the counters.
REQ-004 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port start  input  1  one-cycle run request.
REQ-007 Port op_sel  input  2  expected operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-008 Port a_o  output  1  stimulus a driven to the DUT under test.
REQ-009 Port b_o  output  1  stimulus b driven to the DUT under test.
REQ-010 Port y_i  input  1  DUT response.
REQ-011 Port busy  output  1  high while a run is in progress.
REQ-012 Port done  output  1  high from run completion until the next accepted start or reset.
REQ-013 Port pass  output  1  valid while done is high: 1 when err_count is 0.
REQ-014 Port err_count  output  CNT_W  number of mismatching checks in the current or last run.
REQ-015 Port vec_count  output  CNT_W  number of checks performed in the current or last run.
REQ-016 Port first_fail_vec  output  2  {a,b} of the first mismatching vector.
REQ-017 Port first_fail_valid  output  1  first_fail_vec holds a captured value.

Function
REQ-018 FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-019 IDLE or DONE with start=1 goes to DRIVE; latch op_sel; clear err_count, vec_count and first_fail_valid; set vector index to 0 and the pass counter to 0.
REQ-020 start in DRIVE, SETTLE or CHECK is ignored; op_sel changes mid-run have no effect.
REQ-021 Vector order within a sweep is {a,b} = 00, 01, 10, 11.
REQ-022 DRIVE: register a_o/b_o from the vector index for 1 cycle, then go to SETTLE.
REQ-023 SETTLE: hold a_o/b_o for exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-024 CHECK (1 cycle): compare y_i with the expected value computed from the registered a_o, b_o and latched op; increment vec_count.
REQ-025 On mismatch: increment err_count, saturating at all-ones; when first_fail_valid=0, capture {a_o,b_o} and set first_fail_valid.
REQ-026 After CHECK, go to DRIVE for the next vector; index 11 wraps to 00 and increments the pass counter.
REQ-027 After CHECK of vector 11 in sweep PASSES, go to DONE; a_o=b_o=0 in DONE.
REQ-028 Per-vector latency is SETTLE_CYCLES+2 cycles; done rises exactly PASSES*4*(SETTLE_CYCLES+2) cycles after the cycle start is sampled.
REQ-029 busy=1 in DRIVE, SETTLE and CHECK only.
REQ-030 pass=done AND (err_count==0).
REQ-031 a_o=b_o=0 in IDLE.
REQ-032 Counters and first_fail_* hold their values in DONE until the next accepted start.

Reset
REQ-033 rst takes priority over start in the same cycle.
REQ-034 rst has effect in every state, including mid-run.
REQ-035 rst forces the IDLE state and clears all registered state.
REQ-036 Output values after rst: a_o=b_o=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, first_fail_vec=00, first_fail_valid=0.
REQ-037 The first start is accepted on the cycle after rst deasserts.

Structure
REQ-038 utils_pkg SHALL hold the op_sel enum type (AND/OR/XOR/NAND).
REQ-039 utils_pkg SHALL hold the FSM state enum.
REQ-040 utils_pkg SHALL hold the expected-value function, built on the existing band helper.
REQ-041 The FSM, counters and capture logic SHALL be implemented in one module.
REQ-042 The block SHALL have no sub-module.

Verification
REQ-043 Bench connects a_o/b_o to and_gate and y to y_i; op_sel=00, SETTLE_CYCLES=2, PASSES=1 -> done after 16 cycles, vec_count=4, err_count=0, pass=1.
REQ-044 Same setup, op_sel=01 (OR) -> err_count=2 (vectors 01 and 10), first_fail_vec=01, first_fail_valid=1, pass=0.
REQ-045 PASSES=3 with and_gate, op_sel=00 -> vec_count=12 and done at cycle 48; start pulsed at cycle 5 -> busy stays high and the cycle count is unchanged.
REQ-046 Assert rst during SETTLE of vector 10 -> next cycle IDLE with all outputs at reset values; a new start then completes with pass=1.
REQ-047 y_i tied to 1, CNT_W=2, PASSES=2, op_sel=00 -> err_count saturates at 3, first_fail_vec=00.
REQ-048 start and rst high in the same cycle -> remains IDLE with busy=0.
